// File: rtl/cnn_pkg.sv
// Shared types and constants for the 3x3 convolution sequencer.
package cnn_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD_KER = 3'd1,
    S_STREAM   = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_e;

  localparam int KER_TAPS       = 9;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int RES_W          = 2 * DEF_DATA_WIDTH + 4;

  // Result width that holds 9 full-scale unsigned products without overflow.
  function automatic int res_width(input int dw);
    return 2 * dw + 4;
  endfunction

endpackage

// File: rtl/cnn_conv_sched_if.sv
// Weight, pixel and result handshakes of the convolution sequencer.
interface cnn_conv_sched_if
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  logic                             ker_valid;
  logic [DATA_WIDTH-1:0]            ker_data;
  logic                             ker_ready;
  logic                             pix_valid;
  logic [DATA_WIDTH-1:0]            pix_data;
  logic                             pix_ready;
  logic                             out_valid;
  logic [res_width(DATA_WIDTH)-1:0] out_data;
  logic                             out_ready;

  modport master (
    output ker_valid, ker_data, pix_valid, pix_data, out_ready,
    input  ker_ready, pix_ready, out_valid, out_data
  );

  modport slave (
    input  ker_valid, ker_data, pix_valid, pix_data, out_ready,
    output ker_ready, pix_ready, out_valid, out_data
  );

endinterface

// File: rtl/cnn_line_buffer.sv
// Two-line-plus-three shift chain exposing the 3x3 window; win_o index is row*3+col.
module cnn_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  shift_en_i,
  input  logic [DATA_WIDTH-1:0] pix_i,
  output logic [DATA_WIDTH-1:0] win_o [9]
);

  localparam int DEPTH = 2 * IMG_W + 3;

  logic [DATA_WIDTH-1:0] chain_q [DEPTH];
  logic [DATA_WIDTH-1:0] chain_d [DEPTH];

  // Newest pixel enters tap 0; every entry moves one place on accept.
  always_comb begin
    chain_d = chain_q;
    if (shift_en_i) begin
      chain_d[0] = pix_i;
      for (int i = 1; i < DEPTH; i++) begin
        chain_d[i] = chain_q[i-1];
      end
    end else begin
      chain_d = chain_q;
    end
  end

  // Chain storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        chain_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      chain_q <= chain_d;
    end
  end

  // Bottom-right of the window is the newest pixel, top-left the oldest.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        win_o[r*3+c] = chain_q[(2-r)*IMG_W + (2-c)];
      end
    end
  end

endmodule

// File: rtl/cnn_conv_sched.sv
// Sequencer for the 3x3 convolution datapath: weight load, window streaming
// and result capture behind a valid/ready output.
module cnn_conv_sched
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             start,
  cnn_conv_sched_if.slave                  bus,
  output logic [DATA_WIDTH-1:0]            img_r0_c0, img_r0_c1, img_r0_c2,
  output logic [DATA_WIDTH-1:0]            img_r1_c0, img_r1_c1, img_r1_c2,
  output logic [DATA_WIDTH-1:0]            img_r2_c0, img_r2_c1, img_r2_c2,
  output logic [DATA_WIDTH-1:0]            ker_r0_c0, ker_r0_c1, ker_r0_c2,
  output logic [DATA_WIDTH-1:0]            ker_r1_c0, ker_r1_c1, ker_r1_c2,
  output logic [DATA_WIDTH-1:0]            ker_r2_c0, ker_r2_c1, ker_r2_c2,
  input  logic [res_width(DATA_WIDTH)-1:0] res_conv,
  output logic                             busy,
  output logic                             done
);

  localparam int RW = res_width(DATA_WIDTH);
  localparam int CW = $clog2(IMG_W);
  localparam int HW = $clog2(IMG_H);

  state_e                state_q, state_d;
  logic [3:0]            kcnt_q, kcnt_d;
  logic [DATA_WIDTH-1:0] ker_q [KER_TAPS];
  logic [DATA_WIDTH-1:0] ker_d [KER_TAPS];
  logic [CW-1:0]         col_q, col_d;
  logic [HW-1:0]         row_q, row_d;
  logic                  win_pend_q, win_pend_d;
  logic                  out_valid_q, out_valid_d;
  logic [RW-1:0]         out_data_q, out_data_d;
  logic                  out_free_s, pix_rdy_s, pix_acc_s, ker_acc_s, capture_s;
  logic [DATA_WIDTH-1:0] win_s [9];

  cnn_line_buffer #(.DATA_WIDTH(DATA_WIDTH), .IMG_W(IMG_W)) u_lb (
    .clk        (clk),
    .resetn     (resetn),
    .shift_en_i (pix_acc_s),
    .pix_i      (bus.pix_data),
    .win_o      (win_s)
  );

  // Handshake qualifiers; pixels stall while a pending window cannot be captured.
  always_comb begin
    out_free_s = !out_valid_q || bus.out_ready;
    ker_acc_s  = (state_q == S_LOAD_KER) && bus.ker_valid;
    pix_rdy_s  = (state_q == S_STREAM) && (!win_pend_q || out_free_s);
    pix_acc_s  = pix_rdy_s && bus.pix_valid;
    capture_s  = win_pend_q && out_free_s;
  end

  // Next-state, counters, weights and output register update.
  always_comb begin
    state_d     = state_q;
    kcnt_d      = kcnt_q;
    ker_d       = ker_q;
    col_d       = col_q;
    row_d       = row_q;
    win_pend_d  = win_pend_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD_KER;
          kcnt_d  = 4'd0;
          col_d   = {CW{1'b0}};
          row_d   = {HW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD_KER: begin
        if (ker_acc_s) begin
          for (int k = 0; k < KER_TAPS; k++) begin
            if (kcnt_q == 4'(k)) begin
              ker_d[k] = bus.ker_data;
            end else begin
              ker_d[k] = ker_q[k];
            end
          end
          kcnt_d = kcnt_q + 4'd1;
          if (kcnt_q == 4'(KER_TAPS - 1)) begin
            state_d = S_STREAM;
          end else begin
            state_d = S_LOAD_KER;
          end
        end else begin
          state_d = S_LOAD_KER;
        end
      end
      S_STREAM: begin
        if (pix_acc_s && (row_q == HW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1))) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: begin
        if (!win_pend_q && !out_valid_q) begin
          state_d = S_DONE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Capture uses the pre-edge window, so it may coincide with a new accept.
    if (capture_s) begin
      out_valid_d = 1'b1;
      out_data_d  = res_conv;
      win_pend_d  = 1'b0;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end

    if (pix_acc_s) begin
      win_pend_d = (row_q >= HW'(2)) && (col_q >= CW'(2));
      if (col_q == CW'(IMG_W - 1)) begin
        col_d = {CW{1'b0}};
        row_d = (row_q == HW'(IMG_H - 1)) ? {HW{1'b0}} : row_q + HW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      col_d = col_d;
    end
  end

  // Sequential state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      kcnt_q      <= 4'd0;
      col_q       <= {CW{1'b0}};
      row_q       <= {HW{1'b0}};
      win_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= {RW{1'b0}};
      for (int k = 0; k < KER_TAPS; k++) begin
        ker_q[k] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      kcnt_q      <= kcnt_d;
      col_q       <= col_d;
      row_q       <= row_d;
      win_pend_q  <= win_pend_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ker_q       <= ker_d;
    end
  end

  assign bus.ker_ready = (state_q == S_LOAD_KER);
  assign bus.pix_ready = pix_rdy_s;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);

  assign img_r0_c0 = win_s[0];  assign img_r0_c1 = win_s[1];  assign img_r0_c2 = win_s[2];
  assign img_r1_c0 = win_s[3];  assign img_r1_c1 = win_s[4];  assign img_r1_c2 = win_s[5];
  assign img_r2_c0 = win_s[6];  assign img_r2_c1 = win_s[7];  assign img_r2_c2 = win_s[8];
  assign ker_r0_c0 = ker_q[0];  assign ker_r0_c1 = ker_q[1];  assign ker_r0_c2 = ker_q[2];
  assign ker_r1_c0 = ker_q[3];  assign ker_r1_c1 = ker_q[4];  assign ker_r1_c2 = ker_q[5];
  assign ker_r2_c0 = ker_q[6];  assign ker_r2_c1 = ker_q[7];  assign ker_r2_c2 = ker_q[8];

endmodule

// File: doc/cnn_conv_sched.md
Name: cnn_conv_sched

Overview:
Sequencer for the combinational 3x3 convolution datapath (nine multipliers plus adder tree, unsigned, 2*DATA_WIDTH+4-bit result). It loads nine kernel weights serially, accepts a row-major image pixel stream, and forms the 3x3 sliding window with a two-line buffer. It drives the window and weights to the datapath and registers each valid-convolution result (no padding) behind a valid/ready output handshake. It sits between the pixel/weight source (DMA or testbench) and the downstream result sink.

Parameters:
DATA_WIDTH, 8, pixel and weight width (unsigned)
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in rows (>=3)

Ports:
clk  in  1  clock, rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a frame; ignored unless state is IDLE
ker_valid  in  1  weight available
ker_data  in  DATA_WIDTH  weight, row-major order k00,k01,k02,k10..k22
ker_ready  out  1  weight accepted when ker_valid && ker_ready
pix_valid  in  1  pixel available
pix_data  in  DATA_WIDTH  pixel, row-major
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
img_r{0..2}_c{0..2}  out  DATA_WIDTH each  window taps to datapath
ker_r{0..2}_c{0..2}  out  DATA_WIDTH each  weight registers to datapath
res_conv  in  2*DATA_WIDTH+4  combinational result from datapath
out_valid  out  1  out_data holds an unconsumed result
out_data  out  2*DATA_WIDTH+4  registered convolution result
out_ready  in  1  sink accepts when out_valid && out_ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at end of frame

Behaviour:
- Reset (resetn=0, asynchronous, any state): state=IDLE; all outputs 0, including the weight registers, line buffer, counters, out_valid, done and win_pend. An in-flight frame is abandoned.
- FSM states:
  - IDLE: start moves to LOAD_KER.
  - LOAD_KER: ker_ready=1. Each handshake writes the weight at index kcnt and increments kcnt. Accepting the 9th weight moves to STREAM.
  - STREAM: pixel accept per the handshake below. Accepting pixel (IMG_H-1, IMG_W-1) moves to DRAIN.
  - DRAIN: waits until win_pend=0 and out_valid=0, then moves to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Weights persist after DONE until the next LOAD_KER overwrites them.
- ker_ready=0 and pix_ready=0 outside their states.
- Line buffer: shift chain of 2*IMG_W+3 entries. An accepted pixel enters tap 0 and all entries shift by one.
- Window mapping:
  - r2_c2=tap0, r2_c1=tap1, r2_c0=tap2
  - r1_c2=tap IMG_W, r1_c1=IMG_W+1, r1_c0=IMG_W+2
  - r0_c2=tap 2*IMG_W, r0_c1=2*IMG_W+1, r0_c0=2*IMG_W+2
- Counters: row/col track the accepted pixel. col wraps IMG_W-1 -> 0 and increments row.
- win_pend: set at the accept edge when the accepted pixel has row>=2 and col>=2.
- out_free = !out_valid || out_ready.
- Capture: when win_pend && out_free, at the next edge out_data <= res_conv, out_valid <= 1, win_pend <= 0.
- pix_ready = (state==STREAM) && (!win_pend || out_free), so the window never shifts before its result is captured.
- Capture and accept may occur on the same edge. Capture samples the pre-edge window; the new pixel's win_pend is set at that same edge.
- Latency: a pixel completing a window is accepted at edge E; out_valid is high after edge E+1 if the sink is not stalling.
- Throughput: one pixel/cycle with out_ready held high.
- Output count per frame: (IMG_H-2)*(IMG_W-2), in row-major window order.
- Output retirement: out_valid clears on handshake unless a capture occurs at the same edge, in which case it stays 1 with the new data.
- out_data stays stable while out_valid && !out_ready.
- Arithmetic: unsigned throughout. The 20-bit result (DATA_WIDTH=8) holds the worst case 9*255*255=585225 without overflow. The block does no arithmetic itself.
- start during a frame: ignored. Pixels in LOAD_KER are not accepted.

Decomposition:
- Shared package cnn_pkg:
  - FSM state encoding (IDLE, LOAD_KER, STREAM, DRAIN, DONE)
  - KER_TAPS=9
  - result-width localparam RES_W = 2*DATA_WIDTH+4
- One sub-module, cnn_line_buffer: parameterised shift chain (DATA_WIDTH, IMG_W) with shift-enable input. It exposes the nine window taps and is reset to zero.
- FSM, counters, weight registers and output register stay in cnn_conv_sched.

Test Plan:
1. IMG_W=IMG_H=4, kernel all 1, pixels 1..16 with out_ready=1 -> out_data 54, 63, 90, 99 in order; done pulses once; busy drops after.
2. Same image, kernel centre k11=1 and all others 0 -> outputs 6, 7, 10, 11.
3. Kernel all 255, pixels all 255 -> every output 585225, with no overflow in 20 bits.
4. Scenario 1 with out_ready=0 for 5 cycles after the first out_valid:
   - out_data is held at 54.
   - pix_ready drops once the next complete window is pending.
   - no pixel is lost.
   - the final sequence is still 54, 63, 90, 99.
5. Pixels driven during LOAD_KER are not accepted. A start pulse mid-STREAM is ignored, leaving the frame's results unchanged.
6. resetn asserted mid-STREAM -> state IDLE, out_valid=0, weights 0. A following full frame gives the scenario 1 results.
